// File: rtl/phys_free_list.sv
// Physical register free list for register renaming: a circular buffer of free tags
// with a speculative head for allocation and a committed head for misprediction rollback.
module phys_free_list #(
  parameter int NUM_PHYS = 64,
  parameter int NUM_ARCH = 32,
  parameter int PTAG_W   = $clog2(NUM_PHYS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_req,
  output logic              alloc_valid,
  output logic [PTAG_W-1:0] alloc_tag,
  input  logic              commit_valid,
  input  logic              free_valid,
  input  logic [PTAG_W-1:0] free_tag,
  input  logic              recover,
  output logic [PTAG_W:0]   free_count,
  output logic              err
);

  localparam int PTR_W = PTAG_W + 1;
  localparam logic [PTR_W-1:0] CAP       = PTR_W'(NUM_PHYS);
  localparam logic [PTR_W-1:0] INIT_TAIL = PTR_W'(NUM_PHYS - NUM_ARCH);

  logic [PTAG_W-1:0] tag_mem [NUM_PHYS];
  logic [PTR_W-1:0]  tail;
  logic [PTR_W-1:0]  spec_head;
  logic [PTR_W-1:0]  commit_head;
  logic [PTR_W-1:0]  spec_depth;
  logic [PTR_W-1:0]  live_depth;
  logic [PTR_W-1:0]  commit_head_nxt;
  logic [PTR_W-1:0]  spec_head_nxt;
  logic              alloc_fire;
  logic              free_drop;
  logic              free_ok;
  logic              commit_bad;
  logic              commit_ok;
  logic              order_bad;

  // Pointers carry a wrap bit, so plain subtraction gives wrap-aware distances.
  assign free_count  = tail - spec_head;
  assign spec_depth  = spec_head - commit_head;
  assign live_depth  = tail - commit_head;

  assign alloc_valid = (free_count != '0) && !recover;
  assign alloc_tag   = tag_mem[spec_head[PTAG_W-1:0]];
  assign alloc_fire  = alloc_req && alloc_valid;

  assign free_drop   = free_valid && (free_count == CAP);
  assign free_ok     = free_valid && !free_drop;
  assign commit_bad  = commit_valid && (commit_head == spec_head);
  assign commit_ok   = commit_valid && !commit_bad;

  // Any distance beyond the buffer size means commit_head <= spec_head <= tail is broken.
  assign order_bad   = (spec_depth > CAP) || (free_count > CAP) || (live_depth > CAP);

  always_comb begin
    commit_head_nxt = commit_ok ? commit_head + PTR_W'(1) : commit_head;
    spec_head_nxt   = spec_head;
    if (recover) begin
      spec_head_nxt = commit_head_nxt;
    end else if (alloc_fire) begin
      spec_head_nxt = spec_head + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PHYS; i++) begin
        tag_mem[i] <= (i < NUM_PHYS - NUM_ARCH) ? PTAG_W'(NUM_ARCH + i) : '0;
      end
      tail        <= INIT_TAIL;
      spec_head   <= '0;
      commit_head <= '0;
      err         <= 1'b0;
    end else begin
      if (free_ok) begin
        tag_mem[tail[PTAG_W-1:0]] <= free_tag;
        tail                      <= tail + PTR_W'(1);
      end
      spec_head   <= spec_head_nxt;
      commit_head <= commit_head_nxt;
      if (free_drop || commit_bad || order_bad) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_phys_free_list.sv
// Bench for phys_free_list: constant vector table plus a queue-based reference model.
module tb_phys_free_list;
  localparam int NUM_PHYS = 64;
  localparam int NUM_ARCH = 32;
  localparam int PTAG_W   = 6;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              alloc_req = 1'b0;
  logic              commit_valid = 1'b0;
  logic              free_valid = 1'b0;
  logic              recover = 1'b0;
  logic [PTAG_W-1:0] free_tag = '0;
  logic              alloc_valid;
  logic [PTAG_W-1:0] alloc_tag;
  logic [PTAG_W:0]   free_count;
  logic              err;

  always #5 clk = ~clk;

  phys_free_list #(.NUM_PHYS(NUM_PHYS), .NUM_ARCH(NUM_ARCH), .PTAG_W(PTAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .alloc_req(alloc_req), .alloc_valid(alloc_valid),
    .alloc_tag(alloc_tag), .commit_valid(commit_valid), .free_valid(free_valid),
    .free_tag(free_tag), .recover(recover), .free_count(free_count), .err(err)
  );

  typedef struct {
    string             name;
    bit                ck_tag;
    logic              v;
    logic [PTAG_W-1:0] tag;
    logic [PTAG_W:0]   cnt;
    logic              e;
  } exp_t;

  typedef struct packed {
    bit              rs, a, c, r;
    bit              ck;
    logic            v;
    logic [5:0]      tag;
    logic [6:0]      cnt;
    logic            e;
  } row_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_avail[$];
  int   m_pend[$];
  int   m_ret[$];
  bit   m_err;

  task automatic chk(string nm, string fld, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s actual=%0d required=%0d", nm, fld, act, req);
    end
  endtask

  // Scoreboard consumer: compares the record pushed for this cycle.
  initial forever begin
    exp_t x;
    @(negedge clk);
    #2;
    if (sb.size() != 0) begin
      x = sb.pop_front();
      chk(x.name, "alloc_valid", 32'(alloc_valid), 32'(x.v));
      chk(x.name, "free_count", 32'(free_count), 32'(x.cnt));
      chk(x.name, "err", 32'(err), 32'(x.e));
      if (x.ck_tag && x.v) chk(x.name, "alloc_tag", 32'(alloc_tag), 32'(x.tag));
    end
  end

  task automatic drive(bit r_n, bit a, bit c, bit f, logic [PTAG_W-1:0] ft, bit rc);
    @(negedge clk);
    #1;
    rst_n        = r_n;
    alloc_req    = a;
    commit_valid = c;
    free_valid   = f;
    free_tag     = ft;
    recover      = rc;
  endtask

  function automatic void model_reset();
    m_avail.delete();
    m_pend.delete();
    m_ret.delete();
    for (int i = 0; i < NUM_PHYS - NUM_ARCH; i++) m_avail.push_back(NUM_ARCH + i);
    for (int i = 0; i < NUM_ARCH; i++) m_ret.push_back(i);
    m_err = 1'b0;
  endfunction

  task automatic do_reset(string nm);
    exp_t x;
    drive(1'b0, 0, 0, 0, '0, 0);
    model_reset();
    x = '{nm, 1'b1, 1'b1, PTAG_W'(NUM_ARCH), (PTAG_W+1)'(NUM_PHYS - NUM_ARCH), 1'b0};
    sb.push_back(x);
  endtask

  task automatic step_model(string nm, bit a, bit c, bit f, logic [PTAG_W-1:0] ft, bit rc);
    exp_t x;
    bit fire, drop, cbad, inv;
    drive(1'b1, a, c, f, ft, rc);
    x.name   = nm;
    x.ck_tag = 1'b1;
    x.v      = (m_avail.size() != 0) && !rc;
    x.tag    = (m_avail.size() != 0) ? PTAG_W'(m_avail[0]) : '0;
    x.cnt    = (PTAG_W+1)'(m_avail.size());
    x.e      = m_err;
    sb.push_back(x);
    inv  = (m_avail.size() + m_pend.size()) > NUM_PHYS;
    drop = f && (m_avail.size() == NUM_PHYS);
    cbad = c && (m_pend.size() == 0);
    fire = a && (m_avail.size() != 0) && !rc;
    if (c && !cbad) m_ret.push_back(m_pend.pop_front());
    if (rc) begin
      for (int i = m_pend.size() - 1; i >= 0; i--) m_avail.push_front(m_pend[i]);
      m_pend.delete();
    end else if (fire) begin
      m_pend.push_back(m_avail.pop_front());
    end
    if (f && !drop) m_avail.push_back(int'(ft));
    if (drop || cbad || inv) m_err = 1'b1;
  endtask

  function automatic row_t mk(bit rs, bit a, bit c, bit r, bit ck, logic v, int tag, int cnt, logic e);
    row_t t;
    t = '{rs, a, c, r, ck, v, 6'(tag), 7'(cnt), e};
    return t;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    row_t vec[20];
    exp_t x;
    //               rs a  c  r  ck v  tag cnt e
    vec[0]  = mk(1, 0, 0, 0, 1, 1, 32, 32, 0);
    vec[1]  = mk(0, 1, 0, 0, 1, 1, 32, 32, 0);
    vec[2]  = mk(0, 1, 0, 0, 1, 1, 33, 31, 0);
    vec[3]  = mk(0, 1, 0, 0, 1, 1, 34, 30, 0);
    vec[4]  = mk(0, 1, 0, 0, 1, 1, 35, 29, 0);
    vec[5]  = mk(0, 1, 0, 0, 1, 1, 36, 28, 0);
    vec[6]  = mk(0, 0, 1, 0, 1, 1, 37, 27, 0);
    vec[7]  = mk(0, 0, 1, 0, 1, 1, 37, 27, 0);
    vec[8]  = mk(0, 0, 0, 1, 0, 0, 0, 27, 0);
    vec[9]  = mk(0, 0, 0, 0, 1, 1, 34, 30, 0);
    vec[10] = mk(0, 1, 0, 0, 1, 1, 34, 30, 0);
    vec[11] = mk(1, 0, 0, 0, 1, 1, 32, 32, 0);
    vec[12] = mk(0, 1, 0, 0, 1, 1, 32, 32, 0);
    vec[13] = mk(0, 1, 0, 0, 1, 1, 33, 31, 0);
    vec[14] = mk(0, 1, 0, 0, 1, 1, 34, 30, 0);
    vec[15] = mk(0, 0, 1, 0, 1, 1, 35, 29, 0);
    vec[16] = mk(0, 1, 1, 1, 0, 0, 0, 29, 0);
    vec[17] = mk(0, 0, 0, 0, 1, 1, 34, 30, 0);
    vec[18] = mk(0, 0, 1, 0, 1, 1, 34, 30, 0);
    vec[19] = mk(0, 0, 0, 0, 1, 1, 34, 30, 1);

    for (int i = 0; i < 20; i++) begin
      drive(!vec[i].rs, vec[i].a, vec[i].c, 1'b0, '0, vec[i].r);
      x = '{$sformatf("vec%0d", i), vec[i].ck, vec[i].v, vec[i].tag, vec[i].cnt, vec[i].e};
      sb.push_back(x);
    end

    // Drain the free list, then free and allocate together while empty.
    do_reset("reset_drain");
    for (int i = 0; i < NUM_PHYS - NUM_ARCH; i++) step_model("drain", 1, 0, 0, '0, 0);
    step_model("empty_free_alloc", 1, 0, 1, PTAG_W'(7), 0);
    step_model("after_free", 0, 0, 0, '0, 0);

    // Overfill: the 33rd free is dropped and flags err.
    do_reset("reset_fill");
    for (int i = 0; i < NUM_PHYS - NUM_ARCH + 1; i++) step_model("fill", 0, 0, 1, PTAG_W'(i), 0);
    step_model("after_fill", 0, 0, 0, '0, 0);

    // Long mixed traffic so every pointer wraps several times.
    do_reset("reset_wrap");
    for (int k = 0; k < 600; k++) begin
      bit a, c, f, r;
      logic [PTAG_W-1:0] ft;
      a  = ($urandom_range(0, 9) < 7);
      c  = (m_pend.size() != 0) && ($urandom_range(0, 1) == 1);
      r  = ($urandom_range(0, 19) == 0);
      f  = (m_ret.size() != 0) && ($urandom_range(0, 1) == 1);
      ft = '0;
      if (f) ft = PTAG_W'(m_ret.pop_front());
      step_model("wrap", a, c, f, ft, r);
    end
    step_model("wrap_end", 0, 0, 0, '0, 0);

    repeat (3) @(negedge clk);
    #3;
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
